// File: rtl/axi4_lite_result_reader.sv
// AXI4-Lite master that polls an accelerator status word, then reads ten
// class scores and reports the signed argmax (lowest index wins ties).
module axi4_lite_result_reader #(
    parameter int POLL_GAP  = 8,
    parameter int MAX_POLLS = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic [6:0]  m_axil_araddr,
    output logic [2:0]  m_axil_arprot,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    output logic [6:0]  m_axil_awaddr,
    output logic [2:0]  m_axil_awprot,
    output logic        m_axil_awvalid,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    output logic        m_axil_bready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  class_idx,
    output logic [31:0] class_score,
    output logic        err_timeout,
    output logic        err_resp
);

    typedef enum logic [2:0] {
        IDLE, POLL_AR, POLL_R, GAP, DATA_AR, DATA_R, FINISH
    } state_t;

    localparam logic [6:0] STATUS_ADDR = 7'h28;

    state_t             state, state_nx;
    logic [3:0]         k;
    logic [15:0]        poll_cnt;
    logic [7:0]         gap_cnt;
    logic signed [31:0] best_score;
    logic [3:0]         best_idx;
    logic               r_ok, r_err, status_ready, last_poll, gap_last;

    assign m_axil_arprot  = 3'b000;
    assign m_axil_awaddr  = 7'd0;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = 1'b0;
    assign m_axil_wdata   = 32'd0;
    assign m_axil_wstrb   = 4'd0;
    assign m_axil_wvalid  = 1'b0;
    assign m_axil_bready  = 1'b1;

    assign r_ok         = m_axil_rvalid && m_axil_rready && (m_axil_rresp == 2'b00);
    assign r_err        = m_axil_rvalid && m_axil_rready && (m_axil_rresp != 2'b00);
    assign status_ready = (m_axil_rdata == 32'hFFFF_FFFF);
    assign last_poll    = (poll_cnt == 16'(MAX_POLLS - 1));
    assign gap_last     = (gap_cnt == 8'(POLL_GAP - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_araddr  = 7'd0;
        busy           = (state != IDLE);
        unique case (state)
            IDLE:    if (start) state_nx = POLL_AR;
            POLL_AR: begin
                m_axil_arvalid = 1'b1;
                m_axil_araddr  = STATUS_ADDR;
                if (m_axil_arready) state_nx = POLL_R;
            end
            POLL_R: begin
                m_axil_rready = 1'b1;
                m_axil_araddr = STATUS_ADDR;
                if (r_err) state_nx = IDLE;
                else if (r_ok) begin
                    if (status_ready)   state_nx = DATA_AR;
                    else if (last_poll) state_nx = IDLE;
                    else                state_nx = GAP;
                end
            end
            GAP:     if (gap_last) state_nx = POLL_AR;
            DATA_AR: begin
                m_axil_arvalid = 1'b1;
                m_axil_araddr  = {1'b0, k, 2'b00};
                if (m_axil_arready) state_nx = DATA_R;
            end
            DATA_R: begin
                m_axil_rready = 1'b1;
                m_axil_araddr = {1'b0, k, 2'b00};
                if (r_err) state_nx = IDLE;
                else if (r_ok) state_nx = (k == 4'd9) ? FINISH : DATA_AR;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            k           <= 4'd0;
            poll_cnt    <= 16'd0;
            gap_cnt     <= 8'd0;
            best_score  <= 32'sd0;
            best_idx    <= 4'd0;
            done        <= 1'b0;
            class_idx   <= 4'd0;
            class_score <= 32'd0;
            err_timeout <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            done <= (state == FINISH);
            unique case (state)
                IDLE: if (start) begin
                    err_timeout <= 1'b0;
                    err_resp    <= 1'b0;
                    poll_cnt    <= 16'd0;
                end
                POLL_R: begin
                    if (r_err) err_resp <= 1'b1;
                    else if (r_ok) begin
                        if (status_ready) k <= 4'd0;
                        else if (last_poll) err_timeout <= 1'b1;
                        else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            gap_cnt  <= 8'd0;
                        end
                    end
                end
                GAP: gap_cnt <= gap_cnt + 8'd1;
                DATA_R: begin
                    if (r_err) err_resp <= 1'b1;
                    else if (r_ok) begin
                        // strict greater-than keeps the lower index on ties
                        if (k == 4'd0 || $signed(m_axil_rdata) > best_score) begin
                            best_score <= $signed(m_axil_rdata);
                            best_idx   <= k;
                        end
                        k <= k + 4'd1;
                    end
                end
                FINISH: begin
                    class_idx   <= best_idx;
                    class_score <= best_score;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_result_reader.sv
// Randomized scoreboard bench for axi4_lite_result_reader with an
// AXI4-Lite slave model serving a status word and ten scores.
module tb_axi4_lite_result_reader;

    localparam int POLL_GAP = 8;
    localparam int MAXP     = 4;

    typedef struct {
        bit done;
        int idx;
        int score;
        bit et;
        bit er;
    } res_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready = 1'b0;
    logic [31:0] m_axil_rdata = 32'd0;
    logic [1:0]  m_axil_rresp = 2'b00;
    logic        m_axil_rvalid = 1'b0;
    logic        m_axil_rready;
    logic [6:0]  m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_bready;
    logic        busy, done, err_timeout, err_resp;
    logic [3:0]  class_idx;
    logic [31:0] class_score;

    axi4_lite_result_reader #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAXP)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_wdata(m_axil_wdata),
        .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_bready(m_axil_bready), .busy(busy), .done(done),
        .class_idx(class_idx), .class_score(class_score),
        .err_timeout(err_timeout), .err_resp(err_resp)
    );

    always #5 aclk = ~aclk;

    int   nchk = 0;
    int   npass = 0;
    int   cyc = 0;
    res_t exp_res[$];
    logic [6:0] exp_addr[$];
    bit   ign = 1'b0;

    int cfg_scores[10];
    int cfg_nbad, cfg_err, ar_stall, polls, dreads;
    int last_idx = 0;
    int last_score = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(posedge aclk) cyc++;

    // slave model: samples handshakes at the edge, drives 1 time unit later
    bit s_ar_hs, s_r_hs, s_rst, s_pend;
    logic [6:0] s_a, s_paddr;
    int s_dly, s_k;
    always @(posedge aclk) begin
        s_ar_hs = m_axil_arvalid && m_axil_arready;
        s_r_hs  = m_axil_rvalid && m_axil_rready;
        s_rst   = !aresetn;
        s_a     = m_axil_araddr;
        #1;
        if (s_rst) begin
            m_axil_arready = 1'b0;
            m_axil_rvalid  = 1'b0;
            s_pend         = 1'b0;
        end else begin
            if (s_r_hs) m_axil_rvalid = 1'b0;
            if (s_ar_hs) begin
                s_pend  = 1'b1;
                s_paddr = s_a;
                s_dly   = $urandom_range(0, 2);
            end
            if (s_pend && !m_axil_rvalid) begin
                if (s_dly == 0) begin
                    s_pend = 1'b0;
                    m_axil_rvalid = 1'b1;
                    m_axil_rresp  = 2'b00;
                    if (s_paddr == 7'h28) begin
                        m_axil_rdata = (cfg_nbad < 0 || polls < cfg_nbad) ?
                                       32'hBADBADBA : 32'hFFFFFFFF;
                        polls++;
                    end else begin
                        s_k = int'(s_paddr) / 4;
                        m_axil_rdata = (s_k < 10) ? 32'(cfg_scores[s_k]) : 32'd0;
                        if (dreads == cfg_err) m_axil_rresp = 2'b10;
                        dreads++;
                    end
                end else s_dly--;
            end
            if (m_axil_arvalid && ar_stall > 0) begin
                m_axil_arready = 1'b0;
                ar_stall--;
            end else begin
                m_axil_arready = m_axil_arvalid && ($urandom_range(0, 3) != 0);
            end
        end
    end

    // monitor: address scoreboard, AR stability, poll spacing, results
    bit pbusy, pdone, par_wait;
    logic [6:0] paddr;
    int last_stat = -1;
    res_t m_e;
    always @(negedge aclk) begin
        if (!aresetn) begin
            pbusy = 0; pdone = 0; par_wait = 0; last_stat = -1;
        end else if (!ign) begin
            if (par_wait) begin
                chk("arvalid_hold", longint'(m_axil_arvalid), 1);
                chk("araddr_hold", longint'(m_axil_araddr), longint'(paddr));
            end
            par_wait = m_axil_arvalid && !m_axil_arready;
            paddr    = m_axil_araddr;
            if (m_axil_arvalid && m_axil_arready) begin
                if (exp_addr.size() == 0) begin
                    nchk++;
                    $display("FAIL ar_unexpected: got addr %0h expected no read", m_axil_araddr);
                end else chk("araddr", longint'(m_axil_araddr), longint'(exp_addr.pop_front()));
                if (m_axil_araddr == 7'h28) begin
                    if (last_stat >= 0)
                        chk("poll_gap", longint'(cyc - last_stat >= POLL_GAP + 2), 1);
                    last_stat = cyc;
                end
            end
            if (done) begin
                chk("done_single", longint'(pdone), 0);
                chk("done_at_end", longint'(pbusy && !busy), 1);
            end
            if (pbusy && !busy) begin
                if (exp_res.size() == 0) begin
                    nchk++;
                    $display("FAIL res_unexpected: got end of transaction expected none");
                end else begin
                    m_e = exp_res.pop_front();
                    chk("done", longint'(done), longint'(m_e.done));
                    chk("class_idx", longint'(class_idx), longint'(m_e.idx));
                    chk("class_score", longint'($signed(class_score)), longint'(m_e.score));
                    chk("err_timeout", longint'(err_timeout), longint'(m_e.et));
                    chk("err_resp", longint'(err_resp), longint'(m_e.er));
                end
            end
            if (!busy) last_stat = -1;
            pbusy = busy;
            pdone = done;
        end
    end

    // reference model: predicts the read sequence and outcome
    task automatic predict();
        res_t r;
        int npoll, nd, bi, bs;
        bit tmo;
        tmo   = (cfg_nbad < 0 || cfg_nbad >= MAXP);
        npoll = tmo ? MAXP : cfg_nbad + 1;
        for (int i = 0; i < npoll; i++) exp_addr.push_back(7'h28);
        r = '{done: 0, idx: last_idx, score: last_score, et: 0, er: 0};
        if (tmo) r.et = 1;
        else begin
            nd = (cfg_err >= 0 && cfg_err < 10) ? cfg_err + 1 : 10;
            for (int i = 0; i < nd; i++) exp_addr.push_back(7'(4 * i));
            if (nd < 10) r.er = 1;
            else begin
                bi = 0;
                bs = cfg_scores[0];
                for (int i = 1; i < 10; i++)
                    if (cfg_scores[i] > bs) begin bs = cfg_scores[i]; bi = i; end
                last_idx = bi;
                last_score = bs;
                r = '{done: 1, idx: bi, score: bs, et: 0, er: 0};
            end
        end
        exp_res.push_back(r);
    endtask

    task automatic run(input int nbad, input int erat, input int stall,
                       input int extra, input bit rel_rst);
        bit fin;
        int ex;
        cfg_nbad = nbad; cfg_err = erat; polls = 0; dreads = 0;
        predict();
        @(posedge aclk); #1;
        ar_stall = stall;
        if (rel_rst) aresetn = 1'b1;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        fin = 0;
        ex = extra;
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            if (!busy) begin fin = 1; break; end
            if (ex > 0 && c % 4 == 1) begin start = 1'b1; ex--; end
            else start = 1'b0;
        end
        start = 1'b0;
        if (!fin) begin
            nchk++;
            $display("FAIL run_timeout: got busy after 3000 cycles expected idle");
        end
        @(posedge aclk); @(posedge aclk);
        chk("addr_q_empty", longint'(exp_addr.size()), 0);
        chk("res_q_empty", longint'(exp_res.size()), 0);
        exp_addr.delete();
        exp_res.delete();
    endtask

    initial begin
        int s34[10] = '{5, -3, 9, 2, 9, 0, 1, -7, 4, 8};
        int r;
        bit hit;
        cfg_nbad = 0; cfg_err = -1; ar_stall = 0; polls = 0; dreads = 0;
        cfg_scores = s34;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_arvalid", longint'(m_axil_arvalid), 0);
        chk("rst_class_idx", longint'(class_idx), 0);
        chk("rst_bready", longint'(m_axil_bready), 1);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        run(0, -1, 0, 0, 0);
        run(2, -1, 0, 0, 0);
        run(-1, -1, 0, 0, 0);
        run(0, 3, 0, 0, 0);
        run(1, -1, 20, 3, 0);

        // reset in the middle of a data read
        ign = 1'b1;
        cfg_nbad = 0; cfg_err = -1; polls = 0; dreads = 0;
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        hit = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge aclk);
            if (m_axil_rready && m_axil_araddr == 7'h0c) begin hit = 1; break; end
        end
        chk("reached_data_r", longint'(hit), 1);
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_arvalid", longint'(m_axil_arvalid), 0);
        chk("mid_rst_rready", longint'(m_axil_rready), 0);
        chk("mid_rst_araddr", longint'(m_axil_araddr), 0);
        chk("mid_rst_done", longint'(done), 0);
        chk("mid_rst_class_idx", longint'(class_idx), 0);
        chk("mid_rst_class_score", longint'(class_score), 0);
        chk("mid_rst_errs", longint'({err_timeout, err_resp}), 0);
        ign = 1'b0;
        last_idx = 0;
        last_score = 0;
        for (int i = 0; i < 10; i++) cfg_scores[i] = i - 10;
        run(0, -1, 0, 0, 1);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 10; i++) cfg_scores[i] = $urandom_range(0, 20) - 10;
            if (t % 5 == 0) cfg_scores[$urandom_range(0, 9)] = 32'h7FFFFFFF;
            r = $urandom_range(0, 9);
            run(r < 6 ? int'($urandom_range(0, 2)) : (r < 8 ? -1 : 5),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
                $urandom_range(0, 3), t % 2, 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

endmodule

// File: doc/axi4_lite_result_reader.md
AXI4_LITE_RESULT_READER -- requirements
Module: axi4_lite_result_reader

Interface
REQ-001 SHALL have parameter POLL_GAP, default 8, meaning idle cycles between unsuccessful status polls (1..255).
REQ-002 SHALL have parameter MAX_POLLS, default 1024, meaning status polls allowed before timeout (1..65535).
REQ-003 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to read one inference result.
REQ-006 SHALL have port m_axil_araddr  out  7  byte read address.
REQ-007 SHALL have port m_axil_arprot  out  3  constant 3'b000.
REQ-008 SHALL have ports m_axil_arvalid out 1 and m_axil_arready in 1, the AR handshake pair.
REQ-009 SHALL have ports m_axil_rdata in 32, m_axil_rresp in 2 and m_axil_rvalid in 1, the read data channel.
REQ-010 SHALL have port m_axil_rready  out  1  read data accept.
REQ-011 SHALL have write-channel ports, tied off: m_axil_awvalid=0, m_axil_wvalid=0, m_axil_bready=1, awaddr/wdata/wstrb/awprot=0.
REQ-012 SHALL have port busy  out  1  transaction in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port class_idx  out  4  argmax index 0..9.
REQ-015 SHALL have port class_score  out  32  winning score (signed).
REQ-016 SHALL have ports err_timeout out 1 and err_resp out 1, sticky error flags.

Function
REQ-017 SHALL define the register map as score k at byte address 4*k (k=0..9, 0x00..0x24) and status at 0x28; 32'hFFFFFFFF in status means ready, any other value means not ready.
REQ-018 SHALL implement FSM states IDLE, POLL_AR, POLL_R, GAP, DATA_AR, DATA_R, FINISH.
REQ-019 SHALL, in IDLE on start=1, clear both error flags and the poll counter, then go to POLL_AR.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL, in POLL_AR/DATA_AR, drive arvalid=1 with araddr stable until arready=1 is sampled, then deassert arvalid the next cycle and enter POLL_R/DATA_R.
REQ-022 SHALL assert rready=1 only in POLL_R/DATA_R, with at most one outstanding read.
REQ-023 SHALL, on an rvalid=1 beat with rresp!=2'b00, set err_resp, discard the data and return to IDLE without pulsing done.
REQ-024 SHALL, in POLL_R on rdata=FFFFFFFF, set word index k=0 and go to DATA_AR; on any other value, increment the poll counter and go to GAP, or go to IDLE with err_timeout set if the counter reaches MAX_POLLS.
REQ-025 SHALL stay in GAP exactly POLL_GAP cycles before re-entering POLL_AR.
REQ-026 SHALL, in DATA_R on k=0, load best_score=rdata and best_idx=0.
REQ-027 SHALL, in DATA_R for k>0, replace best_score/best_idx only when rdata > best_score as a signed 32-bit comparison, so ties keep the lower index.
REQ-028 SHALL increment k after each DATA_R beat and go to FINISH after k=9, otherwise back to DATA_AR.
REQ-029 SHALL, in FINISH, register class_idx/class_score from the best values, pulse done for one cycle and return to IDLE.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL hold class_idx/class_score until the next successful FINISH; errors SHALL NOT alter them.

Reset
REQ-032 SHALL, on aresetn=0 at a clock edge, set state=IDLE, arvalid=0, rready=0, araddr=0, busy=0, done=0, class_idx=0, class_score=0, err_timeout=0, err_resp=0, k=0, and poll counter=0.
REQ-033 SHALL abandon any in-flight read on reset mid-operation and accept a new start from the first cycle after aresetn=1.

Verification
REQ-034 SHALL pass: status already FFFFFFFF, scores {5,-3,9,2,9,0,1,-7,4,8} -> exactly 11 reads (0x28, 0x00..0x24 in order), done pulse, class_idx=2, class_score=9.
REQ-035 SHALL pass: status reads BADBADBA twice then FFFFFFFF, POLL_GAP=8 -> 3 status reads at least 8 idle cycles apart, then 10 data reads, done.
REQ-036 SHALL pass: status never ready, MAX_POLLS=4 -> exactly 4 status reads, err_timeout=1, busy=0, no done, class outputs unchanged.
REQ-037 SHALL pass: rresp=2'b10 on the 4th data read -> err_resp=1, no further AR, no done; the next start clears err_resp.
REQ-038 SHALL pass: arready held low 20 cycles -> arvalid and araddr stable for all 20 cycles; start pulses while busy produce no extra transaction.
REQ-039 SHALL pass: all scores negative {-10..-1 ascending} -> class_idx=9, class_score=-1; aresetn pulsed mid-DATA_R -> all outputs at reset values.
